// File: rtl/cache_pkg.sv
// Shared definitions for the cacheline burst path.
//   LINE_W / WORD_W : default line and memory word widths in bits.
//   BEATS           : word transactions per line (LINE_W / WORD_W).
//   state_t         : burst sequencer states.
package cache_pkg;

  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int BEATS  = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/line_beat_buf.sv
// Line-wide staging buffer for one burst, plus the published fill register.
//   load / load_data    : parallel load of a writeback line.
//   word_we / word_idx  : write word_in into word [word_idx] of the buffer.
//   word_out            : word [word_idx] of the buffer (writeback data).
//   publish             : copy the buffer, including the word being written
//                         this cycle, into line_out.
//   line_out            : last completed fill; only changes on publish.
module line_beat_buf #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              word_we,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out,
  input  logic              publish,
  output logic [LINE_W-1:0] line_out
);

  logic [LINE_W-1:0] words_q;
  logic [LINE_W-1:0] merged;
  logic [LINE_W-1:0] line_q;

  // Buffer as it will look after this cycle's word write; publishing from
  // here lets the final beat land in line_out on the same edge.
  always_comb begin
    merged = words_q;
    merged[word_idx*WORD_W +: WORD_W] = word_in;
  end

  assign word_out = words_q[word_idx*WORD_W +: WORD_W];

  // NOTE: the staging buffer has no reset; every word is either loaded or
  // written before it is read, and its outputs are gated by state upstream.
  always_ff @(posedge clk) begin
    if (load) begin
      words_q <= load_data;
    end else if (word_we) begin
      words_q <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (publish) begin
      line_q <= merged;
    end
  end

  assign line_out = line_q;

endmodule

// File: rtl/cacheline_burst_ctrl.sv
// Sequences one cacheline fill or writeback as eight back-to-back word
// transactions on the physical memory port.
//   line_read / line_write : line requests, held until line_resp.
//   line_addr              : line address; low line-offset bits ignored.
//   line_wdata             : writeback line, captured on accept.
//   line_rdata             : last completed fill line.
//   line_resp              : one-cycle completion pulse.
//   busy                   : high whenever not IDLE.
//   pmem_*                 : word-wide memory request/response port.
module cacheline_burst_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = cache_pkg::LINE_W,
  parameter int WORD_W = cache_pkg::WORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [ADDR_W-1:0]   line_addr,
  input  logic [LINE_W-1:0]   line_wdata,
  output logic [LINE_W-1:0]   line_rdata,
  output logic                line_resp,
  output logic                busy,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_addr,
  output logic [WORD_W-1:0]   pmem_wdata,
  output logic [WORD_W/8-1:0] pmem_byte_enable,
  input  logic [WORD_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  localparam int BEATS_L = LINE_W / WORD_W;
  localparam int BEAT_W  = $clog2(BEATS_L);
  localparam int WB_W    = $clog2(WORD_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_L - 1);
  // Clears the byte-offset-within-line bits of a line address.
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((LINE_W / 8) - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                accept_wr;
  logic                word_we;
  logic                publish;
  logic                active;
  logic [WORD_W-1:0]   word_out;
  logic [ADDR_W-1:0]   beat_offset;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    accept_wr = 1'b0;
    case (state_q)
      IDLE: begin
        // Writeback wins when both requests are up; the read is not queued.
        if (line_write) begin
          state_d   = WRITE;
          beat_d    = '0;
          base_d    = line_addr & BASE_MASK;
          accept_wr = 1'b1;
        end else if (line_read) begin
          state_d = READ;
          beat_d  = '0;
          base_d  = line_addr & BASE_MASK;
        end
      end
      READ, WRITE: begin
        if (pmem_resp) begin
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  assign word_we = (state_q == READ) && pmem_resp;
  assign publish = word_we && (beat_q == LAST_BEAT);

  line_beat_buf #(
    .LINE_W (LINE_W),
    .WORD_W (WORD_W),
    .IDX_W  (BEAT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_wr),
    .load_data (line_wdata),
    .word_we   (word_we),
    .word_idx  (beat_q),
    .word_in   (pmem_rdata),
    .word_out  (word_out),
    .publish   (publish),
    .line_out  (line_rdata)
  );

  // Base is line-aligned, so the beat offset can simply be OR-ed in.
  assign beat_offset = {{(ADDR_W - BEAT_W - WB_W){1'b0}}, beat_q, {WB_W{1'b0}}};

  assign active           = (state_q == READ) || (state_q == WRITE);
  assign busy             = (state_q != IDLE);
  assign line_resp        = (state_q == DONE);
  assign pmem_read        = (state_q == READ);
  assign pmem_write       = (state_q == WRITE);
  assign pmem_addr        = active ? (base_q | beat_offset) : '0;
  assign pmem_wdata       = (state_q == WRITE) ? word_out : '0;
  assign pmem_byte_enable = active ? '1 : '0;

endmodule

// File: tb/tb_cacheline_burst_ctrl.sv
// Directed testbench for cacheline_burst_ctrl. Inputs change on the falling
// edge, outputs are sampled on the falling edge; the memory responder returns
// word = address for reads.
module tb_cacheline_burst_ctrl;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int MAXC   = 64;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                line_read;
  logic                line_write;
  logic [ADDR_W-1:0]   line_addr;
  logic [LINE_W-1:0]   line_wdata;
  logic [LINE_W-1:0]   line_rdata;
  logic                line_resp;
  logic                busy;
  logic                pmem_read;
  logic                pmem_write;
  logic [ADDR_W-1:0]   pmem_addr;
  logic [WORD_W-1:0]   pmem_wdata;
  logic [WORD_W/8-1:0] pmem_byte_enable;
  logic [WORD_W-1:0]   pmem_rdata;
  logic                pmem_resp;

  always #5 clk = ~clk;

  cacheline_burst_ctrl #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .WORD_W (WORD_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .line_read        (line_read),
    .line_write       (line_write),
    .line_addr        (line_addr),
    .line_wdata       (line_wdata),
    .line_rdata       (line_rdata),
    .line_resp        (line_resp),
    .busy             (busy),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_addr        (pmem_addr),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  int tests_run = 0;
  int fails     = 0;

  // Per-cycle trace (cycle 1 = first cycle after accept) and per-beat log.
  logic              tr_rd   [1:MAXC];
  logic              tr_wr   [1:MAXC];
  logic [31:0]       tr_addr [1:MAXC];
  logic [3:0]        tr_be   [1:MAXC];
  logic [LINE_W-1:0] tr_lrd  [1:MAXC];
  logic [31:0]       bt_addr [0:15];
  logic [31:0]       bt_data [0:15];
  int                n_beats;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [LINE_W-1:0] fill_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(4 * i);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] wb_line(input logic [31:0] first);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = first + 32'(i);
    return l;
  endfunction

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [LINE_W-1:0] wd);
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wd;
  endtask

  // Memory responder: answers each beat after `waits` wait cycles. Stops at
  // the line_resp cycle (resp_cyc) or after max_c cycles (resp_cyc = 0).
  task automatic run_cycles(input int max_c, input int waits, input bit hold,
                            output int resp_cyc);
    int wc;
    wc       = 0;
    resp_cyc = 0;
    n_beats  = 0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      tr_rd[c]   = pmem_read;
      tr_wr[c]   = pmem_write;
      tr_addr[c] = pmem_addr;
      tr_be[c]   = pmem_byte_enable;
      tr_lrd[c]  = line_rdata;
      if (line_resp) begin
        resp_cyc  = c;
        pmem_resp = 1'b0;
        if (!hold) begin
          line_read  = 1'b0;
          line_write = 1'b0;
        end
        break;
      end
      if (pmem_read || pmem_write) begin
        if (wc == waits) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_addr;
          if (n_beats < 16) begin
            bt_addr[n_beats] = pmem_addr;
            bt_data[n_beats] = pmem_wdata;
          end
          n_beats++;
          wc = 0;
        end else begin
          pmem_resp = 1'b0;
          wc++;
        end
      end else begin
        pmem_resp = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_req(1'b0, 1'b0, '0, '0);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    tests_run++;
    if ({busy, pmem_read, pmem_write, line_resp, pmem_addr, pmem_wdata, pmem_byte_enable} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b rd=%b wr=%b resp=%b addr=%h wdata=%h be=%h, expected all 0",
               busy, pmem_read, pmem_write, line_resp, pmem_addr, pmem_wdata, pmem_byte_enable);
    end
    tests_run++;
    if (line_rdata !== '0) begin
      fails++;
      $display("FAIL reset_line_rdata: got %h expected 0", line_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_zero_wait();
    int rc;
    start_req(1'b1, 1'b0, 32'h0000_1040, '0);
    run_cycles(20, 0, 1'b0, rc);
    tests_run++;
    if (rc !== 9) begin
      fails++;
      $display("FAIL fill_resp_cycle: got %0d expected 9", rc);
    end
    tests_run++;
    if (n_beats !== 8) begin
      fails++;
      $display("FAIL fill_beat_count: got %0d expected 8", n_beats);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_addr[i] !== 32'h1040 + 32'(4 * i)) begin
        fails++;
        $display("FAIL fill_addr[%0d]: got %h expected %h", i, bt_addr[i], 32'h1040 + 32'(4 * i));
      end
    end
    for (int c = 1; c <= 8; c++) begin
      tests_run++;
      if (tr_rd[c] !== 1'b1 || tr_wr[c] !== 1'b0) begin
        fails++;
        $display("FAIL fill_read_continuous[c%0d]: rd=%b wr=%b expected rd=1 wr=0", c, tr_rd[c], tr_wr[c]);
      end
    end
    tests_run++;
    if (tr_lrd[8] !== '0) begin
      fails++;
      $display("FAIL fill_partial_hidden: got %h expected 0", tr_lrd[8]);
    end
    tests_run++;
    if (tr_lrd[9] !== fill_line(32'h1040)) begin
      fails++;
      $display("FAIL fill_line_rdata: got %h expected %h", tr_lrd[9], fill_line(32'h1040));
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL fill_back_to_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_writeback_waits();
    int rc;
    logic [31:0] exp_a;
    start_req(1'b0, 1'b1, 32'h0000_2000, wb_line(32'hA0));
    run_cycles(60, 2, 1'b0, rc);
    tests_run++;
    if (rc !== 25) begin
      fails++;
      $display("FAIL wb_resp_cycle: got %0d expected 25", rc);
    end
    tests_run++;
    if (n_beats !== 8) begin
      fails++;
      $display("FAIL wb_beat_count: got %0d expected 8", n_beats);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_addr[i] !== 32'h2000 + 32'(4 * i) || bt_data[i] !== 32'hA0 + 32'(i)) begin
        fails++;
        $display("FAIL wb_beat[%0d]: addr=%h data=%h expected addr=%h data=%h", i, bt_addr[i],
                 bt_data[i], 32'h2000 + 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
    for (int c = 1; c <= 24; c++) begin
      exp_a = 32'h2000 + 32'(4 * ((c - 1) / 3));
      tests_run++;
      if (tr_wr[c] !== 1'b1 || tr_rd[c] !== 1'b0 || tr_be[c] !== 4'hF || tr_addr[c] !== exp_a) begin
        fails++;
        $display("FAIL wb_cycle[c%0d]: wr=%b rd=%b be=%h addr=%h expected wr=1 rd=0 be=f addr=%h",
                 c, tr_wr[c], tr_rd[c], tr_be[c], tr_addr[c], exp_a);
      end
    end
    tests_run++;
    if (line_rdata !== fill_line(32'h1040)) begin
      fails++;
      $display("FAIL wb_rdata_untouched: got %h expected %h", line_rdata, fill_line(32'h1040));
    end
    @(negedge clk);
  endtask

  task automatic test_both_high();
    int rc;
    int n_rd;
    start_req(1'b1, 1'b1, 32'h0000_5000, wb_line(32'h500));
    run_cycles(20, 0, 1'b0, rc);
    n_rd = 0;
    for (int c = 1; c <= 9; c++) if (tr_rd[c] === 1'b1) n_rd++;
    tests_run++;
    if (rc !== 9 || n_beats !== 8 || n_rd !== 0) begin
      fails++;
      $display("FAIL both_write_priority: resp_cycle=%0d beats=%0d reads=%0d expected 9/8/0", rc, n_beats, n_rd);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_data[i] !== 32'h500 + 32'(i)) begin
        fails++;
        $display("FAIL both_wdata[%0d]: got %h expected %h", i, bt_data[i], 32'h500 + 32'(i));
      end
    end
    tests_run++;
    if (line_rdata !== fill_line(32'h1040)) begin
      fails++;
      $display("FAIL both_rdata_untouched: got %h expected %h", line_rdata, fill_line(32'h1040));
    end
    @(negedge clk);
  endtask

  task automatic test_spurious_idle();
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if ({busy, pmem_read, pmem_write, line_resp} !== 4'b0 || line_rdata !== fill_line(32'h1040)) begin
        fails++;
        $display("FAIL spurious_idle[%0d]: busy=%b rd=%b wr=%b resp=%b expected all 0, rdata unchanged",
                 k, busy, pmem_read, pmem_write, line_resp);
      end
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_unaligned();
    int rc;
    start_req(1'b1, 1'b0, 32'h0000_301F, '0);
    run_cycles(20, 0, 1'b0, rc);
    tests_run++;
    if (rc !== 9 || bt_addr[0] !== 32'h3000 || bt_addr[7] !== 32'h301C) begin
      fails++;
      $display("FAIL unaligned_base: resp_cycle=%0d first=%h last=%h expected 9/3000/301c", rc, bt_addr[0], bt_addr[7]);
    end
    tests_run++;
    if (line_rdata !== fill_line(32'h3000)) begin
      fails++;
      $display("FAIL unaligned_rdata: got %h expected %h", line_rdata, fill_line(32'h3000));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int rc;
    start_req(1'b1, 1'b0, 32'h0000_6000, '0);
    run_cycles(4, 0, 1'b0, rc);
    @(negedge clk);
    pmem_resp = 1'b0;
    tests_run++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h6010) begin
      fails++;
      $display("FAIL midburst_beat4: rd=%b addr=%h expected rd=1 addr=6010", pmem_read, pmem_addr);
    end
    rst_n     = 1'b0;
    line_read = 1'b0;
    #1;
    tests_run++;
    if ({busy, pmem_read, pmem_write, line_resp, pmem_addr, pmem_wdata, pmem_byte_enable} !== '0
        || line_rdata !== '0) begin
      fails++;
      $display("FAIL midburst_reset_outputs: busy=%b rd=%b addr=%h be=%h rdata=%h expected all 0",
               busy, pmem_read, pmem_addr, pmem_byte_enable, line_rdata);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    pmem_resp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (line_resp !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL midburst_no_resp[%0d]: resp=%b busy=%b expected 0/0", k, line_resp, busy);
      end
    end
    pmem_resp = 1'b0;
    start_req(1'b1, 1'b0, 32'h0000_7000, '0);
    run_cycles(20, 0, 1'b0, rc);
    tests_run++;
    if (rc !== 9 || line_rdata !== fill_line(32'h7000)) begin
      fails++;
      $display("FAIL midburst_next_fill: resp_cycle=%0d rdata=%h expected 9 / %h", rc, line_rdata, fill_line(32'h7000));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int rc;
    start_req(1'b1, 1'b0, 32'h0000_8000, '0);
    run_cycles(20, 0, 1'b1, rc);
    tests_run++;
    if (rc !== 9) begin
      fails++;
      $display("FAIL b2b_first_resp: got %0d expected 9", rc);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle_gap: busy=%b rd=%b expected 0/0", busy, pmem_read);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || pmem_read !== 1'b1 || pmem_addr !== 32'h8000) begin
      fails++;
      $display("FAIL b2b_second_start: busy=%b rd=%b addr=%h expected 1/1/8000", busy, pmem_read, pmem_addr);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = pmem_addr;
    run_cycles(20, 0, 1'b0, rc);
    tests_run++;
    if (rc !== 8 || line_rdata !== fill_line(32'h8000)) begin
      fails++;
      $display("FAIL b2b_second_done: resp_cycle=%0d rdata=%h expected 8 / %h", rc, line_rdata, fill_line(32'h8000));
    end
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL b2b_stays_idle: busy=%b expected 0", busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_zero_wait();
    test_writeback_waits();
    test_both_high();
    test_spurious_idle();
    test_unaligned();
    test_reset_mid_burst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_ctrl.md
# cacheline_burst_ctrl

Sequencer between the cache's 256-bit line port and the 32-bit physical memory port. Accepts one line read (fill) or line write (writeback), issues eight word transactions on the memory side, assembles or disassembles the line, and returns a single line response. Sits between the cache controller and pmem; it is the control side of the line-width adaptation path.

## Interface

Parameters:
- ADDR_W, 32, byte address width on both sides.
- LINE_W, 256, cacheline width in bits.
- WORD_W, 32, memory word width in bits; BEATS = LINE_W/WORD_W (8) is derived, not overridable.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- line_read  in  1  line fill request; held until line_resp.
- line_write  in  1  line writeback request; held until line_resp.
- line_addr  in  ADDR_W  line address; low log2(LINE_W/8) bits ignored.
- line_wdata  in  LINE_W  writeback data; sampled on accept.
- line_rdata  out  LINE_W  assembled fill data.
- line_resp  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- pmem_read  out  1  word read request.
- pmem_write  out  1  word write request.
- pmem_addr  out  ADDR_W  word address.
- pmem_wdata  out  WORD_W  word write data.
- pmem_byte_enable  out  WORD_W/8  constant all-ones (4'hF) while a request is active, else 0.
- pmem_rdata  in  WORD_W  read data, valid with pmem_resp.
- pmem_resp  in  1  per-word acknowledge.

## Operation

- States: IDLE, READ, WRITE, DONE.
- IDLE: on a clock edge with line_write=1, latch aligned base address and line_wdata, beat=0, go WRITE. Else with line_read=1, latch base, beat=0, go READ. Write has priority when both are high; read is not queued.
- READ: pmem_read=1, pmem_addr=base+4*beat. On an edge with pmem_resp=1, store pmem_rdata into line word [beat] (bits beat*32+:32); if beat==7 go DONE, else beat+1.
- WRITE: pmem_write=1, pmem_addr=base+4*beat, pmem_wdata=latched word [beat]. On pmem_resp edge, same beat advance as READ.
- Word 0 at the lowest address, little-endian word order within the line.
- Without pmem_resp, state, beat, address and data hold indefinitely (any wait-state count).
- DONE: line_resp=1 for exactly one cycle, then IDLE unconditionally. Line requests are not sampled in DONE.
- line_rdata holds the last completed fill until the next fill's DONE. Writes do not disturb line_rdata. Partial fills are never visible.
- pmem_resp in IDLE or DONE is ignored.
- Beat counter is 3 bits; it wraps only through DONE, never to 0 mid-burst.

## Timing

- Reset (async, immediate): state IDLE, beat 0, line_rdata 0, line_resp 0, busy 0, pmem_read 0, pmem_write 0, pmem_addr 0, pmem_wdata 0, pmem_byte_enable 0. Reset mid-burst abandons the burst; no line_resp.
- All outputs are registered-state decodes: request/address for beat n appear the cycle after the edge that accepted beat n-1.
- pmem_read/pmem_write stay high continuously across all 8 beats. A new address after a pmem_resp edge marks a new beat.
- Zero-wait memory (pmem_resp high every active cycle): accept at edge E0; beats captured at E1..E8; line_resp high in the cycle after E8. That is 9 cycles from accept to response.
- Requester drops line_read/line_write at the edge ending the line_resp cycle. A request still high in the following IDLE cycle starts a new burst.

## Structure

- Shared package cache_pkg: LINE_W, WORD_W, BEATS, and the state enum type (IDLE, READ, WRITE, DONE).
- One sub-module, line_beat_buf: LINE_W register with word-indexed write (from pmem_rdata) and word-indexed read (to pmem_wdata), plus parallel load (line_wdata) and parallel output (line_rdata).

## Test plan

- Fill, zero-wait: line_addr=0x0000_1040, memory returns word = address. Required: pmem_addr 0x1040..0x105C in order; line_resp in the 9th cycle after accept; line_rdata = {0x105C,…,0x1040}.
- Writeback with 2 wait cycles per beat: line_wdata word[i]=0xA0+i, line_addr=0x2000. Required: 8 writes to 0x2000..0x201C with matching data and byte_enable 0xF; address held during waits; line_resp after 24 active cycles; line_rdata unchanged.
- Both line_read and line_write high in IDLE. Required: WRITE burst only, no pmem_read.
- rst_n low during beat 4 of a fill. Required: all outputs 0 immediately; no line_resp; the next fill completes normally.
- Unaligned line_addr=0x0000_301F. Required: base 0x3000 used.
- Spurious pmem_resp in IDLE. Required: no state change.
- Back-to-back requests held high past line_resp. Required: exactly one IDLE cycle between bursts.
